// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shifter.
//   XLEN_DEF / SHW_DEF : default operand width and shift-amount width
//   shift_type_e       : operation encoding (SLL, SRL, SRA, ROR)
//   shifter_state_e    : sequencer states (IDLE, SHIFT, DONE)
package shifter_pkg;

   localparam int XLEN_DEF = 32;
   localparam int SHW_DEF  = 5;

   typedef enum logic [1:0] {
      SLL = 2'b00,
      SRL = 2'b01,
      SRA = 2'b10,
      ROR = 2'b11
   } shift_type_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } shifter_state_e;

endpackage

// File: rtl/shifter_seq_shift_step.sv
// shift_step: combinational single-bit shift of the work value.
// Optional feature macro: SHIFTER_SEQ_ROR_EN (enables the rotate-right step).
//   value      : current work value
//   typ        : captured operation type
//   sign       : captured operand MSB, used as SRA fill
//   value_next : work value after one 1-bit step
module shift_step
   import shifter_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [XLEN-1:0] value,
   input  shift_type_e     typ,
   input  logic            sign,
   output logic [XLEN-1:0] value_next
);

   always_comb begin
      value_next = value;
      case (typ)
         SLL: value_next = {value[XLEN-2:0], 1'b0};
         SRL: value_next = {1'b0, value[XLEN-1:1]};
         SRA: value_next = {sign, value[XLEN-1:1]};
`ifdef SHIFTER_SEQ_ROR_EN
         ROR: value_next = {value[0], value[XLEN-1:1]};
`else
         // ROR ops never reach SHIFT in this build; pass through unchanged.
         ROR: value_next = value;
`endif
         default: value_next = value;
      endcase
   end

endmodule

// File: rtl/shifter_seq.sv
// shifter_seq: multi-cycle SLL/SRL/SRA (optionally ROR) unit, one bit per clock,
// behind a start/done handshake.
// Optional feature macro: SHIFTER_SEQ_ROR_EN (type=11 rotates right; otherwise
// type=11 completes immediately with r=a).
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   start      : request, accepted only when not busy
//   a          : operand, captured on accept
//   shamt      : shift amount, captured on accept
//   shift_type : 00=SLL 01=SRL 10=SRA 11=ROR ("type" is a reserved word)
//   busy       : high while shifting
//   done       : one-cycle completion pulse, r valid
//   r          : result register, held until the next completion
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one 1-bit step per clock, counter counting down to 1
// DONE  | r just loaded, done high; may accept a new start
module shifter_seq
   import shifter_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int SHW  = SHW_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [XLEN-1:0] a,
   input  logic [SHW-1:0]  shamt,
   input  logic [1:0]      shift_type,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] r
);

   shifter_state_e  state;
   logic [SHW-1:0]  cnt;
   logic [XLEN-1:0] work;
   shift_type_e     typ_q;
   logic            sign_q;
   logic [XLEN-1:0] step_out;
   logic [SHW-1:0]  start_cnt;

   // Count loaded on accept; a zero count completes in the very next cycle.
   always_comb begin
      start_cnt = shamt;
`ifdef SHIFTER_SEQ_ROR_EN
      start_cnt = shamt;
`else
      if (shift_type == 2'(ROR))
         start_cnt = '0;
`endif
   end

   shift_step #(.XLEN(XLEN)) u_step (
      .value      (work),
      .typ        (typ_q),
      .sign       (sign_q),
      .value_next (step_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         work   <= '0;
         typ_q  <= SLL;
         sign_q <= 1'b0;
         r      <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  work   <= a;
                  cnt    <= start_cnt;
                  typ_q  <= shift_type_e'(shift_type);
                  sign_q <= a[XLEN-1];
                  if (start_cnt == '0) begin
                     state <= DONE;
                     r     <= a;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     state <= SHIFT;
                     busy  <= 1'b1;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            SHIFT: begin
               work <= step_out;
               cnt  <= cnt - SHW'(1);
               if (cnt == SHW'(1)) begin
                  state <= DONE;
                  r     <= step_out;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
